mesi_snoop_ctrl: RTL
====================

# mesi_snoop_ctrl

Parametrised snooping-bus MESI coherence controller serving NUM_CORES private caches over one shared bus. It arbitrates bus requests round-robin and broadcasts each one as a snoop to all other caches. From the collected snoop responses it chooses the data source: a cache-to-cache transfer (FlushOpt), a Modified flush with write-back, or a main-memory read. It returns the line and the final MESI state to the requester and drives state updates to the snoopers. It sits between the per-core cache controllers and the memory adaptor.

## Interface
Parameters:
- NUM_CORES, 4, number of caches on the bus (2..8)
- ADDR_W, 32, line address width
- LINE_W, 256, cacheline data width

State encoding is fixed: I=2'b00, S=2'b01, E=2'b10, M=2'b11. Op encoding is fixed: BusRd=2'b00, BusRdX=2'b01, BusUpgr=2'b10; 2'b11 is reserved.

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CORES  per-core bus request, held until that core's resp_valid
- req_op  in  2*NUM_CORES  per-core op
- req_addr  in  ADDR_W*NUM_CORES  per-core line address
- resp_valid  out  NUM_CORES  one-hot, one-cycle completion pulse to the granted core
- resp_data  out  LINE_W  line for BusRd/BusRdX
- resp_state  out  2  requester's new state
- snp_valid  out  1  snoop broadcast active
- snp_mask  out  NUM_CORES  snooped cores (all except the requester)
- snp_op  out  2  op being snooped
- snp_addr  out  ADDR_W  address being snooped
- snp_ack  in  NUM_CORES  snoop response valid, one cycle per core
- snp_hit  in  NUM_CORES  core holds a valid copy
- snp_state  in  2*NUM_CORES  holder's current state
- snp_data  in  LINE_W*NUM_CORES  holder's line
- snp_upd  out  NUM_CORES  one-cycle state-update strobe to snoopers
- snp_upd_state  out  2  new state for the strobed snoopers
- mem_valid  out  1  memory request
- mem_we  out  1  1 = write-back, 0 = read
- mem_addr  out  ADDR_W  memory request address
- mem_wdata  out  LINE_W  write-back data
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle
- mem_rdata  in  LINE_W  memory read data
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, SNOOP, RESOLVE, WB, MEMRD, RESP.
- **IDLE:** when any req_valid is set, grant the first requester at or after rr_ptr, then go to SNOOP. The granted op and address are latched. rr_ptr is updated to grant+1 (mod NUM_CORES).
- **SNOOP:** snp_valid=1 and snp_mask=~onehot(grant). Per-core acks, hits, states and data are captured into sticky registers. Go to RESOLVE once every masked core has acked; acks on unmasked cores are ignored. There is no timeout.
- **RESOLVE:** selects the source and the final states. "Source" is the lowest-index hitting core, unless some core is in M, in which case the M core is the source.
  - BusRd, M hit: data from the M core; go to WB (write that data to memory); snoopers go to S; requester gets S.
  - BusRd, E/S hit: FlushOpt from the source; go to RESP; snoopers go to S; requester gets S.
  - BusRd, no hit: go to MEMRD; requester gets E.
  - BusRdX, M hit: data from the M core with no write-back (ownership transfers); snoopers go to I; requester gets M.
  - BusRdX, E/S hit: data from the source; snoopers go to I; requester gets M.
  - BusRdX, no hit: go to MEMRD; requester gets M.
  - BusUpgr: no data and no memory access; hitting snoopers go to I; requester gets M; resp_data=0.
  - BusUpgr with an M hit is treated as BusRdX.
  - Reserved op: treated as BusRd.
- **WB:** mem_valid=1, mem_we=1, mem_wdata=source line. On mem_ack, go to RESP.
- **MEMRD:** mem_valid=1, mem_we=0. On mem_ack, capture mem_rdata and go to RESP.
- **RESP:** for one cycle, resp_valid[grant]=1, resp_data/resp_state valid, snp_upd=hit vector (masked), snp_upd_state applied. Return to IDLE.
- A req_valid deasserted before its response is a protocol violation; behaviour is undefined.

## Timing
- Asynchronous reset (rst=0) forces: FSM to IDLE, rr_ptr=0, sticky registers cleared, and every output to 0.
- Reset mid-transaction aborts the transaction with no resp_valid and no snp_upd.
- Best-case latency, with acks in the first SNOOP cycle and mem_ack in the first memory cycle. Request sampled at cycle 0:
  - Cache-to-cache or BusUpgr: snp_valid at cycle 1, RESOLVE at cycle 2, resp_valid at cycle 3.
  - Memory read or write-back: mem_valid at cycle 3, resp_valid at cycle 4.
- A new grant can occur at the earliest in the cycle after RESP.
- mem_* outputs are held stable while mem_valid=1 until mem_ack.
- snp_* outputs are held stable while snp_valid=1.

## Test plan
- Core0 BusRd, no hits, mem_rdata=0xA5.. → mem_valid read at cycle 3; resp_valid=0001, resp_state=E, data=0xA5.. at cycle 4.
- Core1 BusRd while core2 holds E (data 0x11..) → resp_valid at cycle 3, resp_state=S, resp_data=0x11..; snp_upd=0100, snp_upd_state=S; no mem_valid.
- Core0 BusRdX while core3 holds M (0xDE..) and core1 holds I → resp_state=M, data=0xDE..; snp_upd=1000 with state I; no memory write.
- Core2 BusRd while core0 holds M → WB write of the M data to the request address; requester gets S; core0 updated to S.
- All four cores request simultaneously after reset → grants in order 0, 1, 2, 3. Core0 then re-requests → granted after core3. Core2 BusUpgr with cores 0/1 in S → snp_upd=0011 with state I, resp_state=M, no memory access.
- rst asserted while in MEMRD → all outputs 0 immediately; the FSM re-arbitrates from core0 after release.

Source files
------------

// File: rtl/mesi_snoop_ctrl.sv
// rtl/mesi_snoop_ctrl.sv - snooping-bus MESI coherence controller with round-robin arbitration
module mesi_snoop_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [2*NUM_CORES-1:0]        req_op,
    input  logic [ADDR_W*NUM_CORES-1:0]   req_addr,
    output logic [NUM_CORES-1:0]          resp_valid,
    output logic [LINE_W-1:0]             resp_data,
    output logic [1:0]                    resp_state,
    output logic                          snp_valid,
    output logic [NUM_CORES-1:0]          snp_mask,
    output logic [1:0]                    snp_op,
    output logic [ADDR_W-1:0]             snp_addr,
    input  logic [NUM_CORES-1:0]          snp_ack,
    input  logic [NUM_CORES-1:0]          snp_hit,
    input  logic [2*NUM_CORES-1:0]        snp_state,
    input  logic [LINE_W*NUM_CORES-1:0]   snp_data,
    output logic [NUM_CORES-1:0]          snp_upd,
    output logic [1:0]                    snp_upd_state,
    output logic                          mem_valid,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [LINE_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [LINE_W-1:0]             mem_rdata,
    output logic                          busy
);
    localparam int IDX_W = $clog2(NUM_CORES);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_RDX  = 2'b01;
    localparam logic [1:0] OP_UPGR = 2'b10;

    typedef enum logic [2:0] {IDLE, SNOOP, RESOLVE, WB, MEMRD, RESP} state_t;

    state_t                       state, state_nx;
    logic [IDX_W-1:0]             rr_ptr;
    logic [1:0]                   op_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [NUM_CORES-1:0]         mask_q;
    logic [NUM_CORES-1:0]         ack_q;
    logic [NUM_CORES-1:0]         hit_q;
    logic [2*NUM_CORES-1:0]       sstate_q;
    logic [LINE_W*NUM_CORES-1:0]  sdata_q;
    logic [LINE_W-1:0]            data_q;
    logic [1:0]                   rstate_q;
    logic [1:0]                   ustate_q;
    logic [NUM_CORES-1:0]         upd_q;

    logic                         found_hi;
    logic [IDX_W-1:0]             idx_hi, idx_any, gnt_idx;
    logic [NUM_CORES-1:0]         gnt_onehot;
    logic [1:0]                   gnt_op;
    logic [ADDR_W-1:0]            gnt_addr;

    logic                         any_hit, any_m, all_acked;
    logic [LINE_W-1:0]            lo_data, m_data, src_data;
    logic [1:0]                   op_eff;
    logic [LINE_W-1:0]            res_data;
    logic [1:0]                   res_rstate, res_ustate;

    // Round-robin pick: lowest requester at/after rr_ptr, else lowest requester overall (wrap)
    always_comb begin
        found_hi   = 1'b0;
        idx_hi     = '0;
        idx_any    = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                idx_any = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = IDX_W'(i);
                end
            end
        end
        gnt_idx    = found_hi ? idx_hi : idx_any;
        gnt_onehot = '0;
        gnt_op     = '0;
        gnt_addr   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (IDX_W'(i) == gnt_idx) begin
                gnt_onehot[i] = 1'b1;
                gnt_op        = req_op[2*i +: 2];
                gnt_addr      = req_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    // Source selection from the sticky snoop results: an M holder wins, else the lowest hitter
    always_comb begin
        any_hit   = |hit_q;
        any_m     = 1'b0;
        lo_data   = '0;
        m_data    = '0;
        all_acked = (((ack_q | snp_ack) & mask_q) == mask_q);
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit_q[i]) lo_data = sdata_q[LINE_W*i +: LINE_W];
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (hit_q[i] && sstate_q[2*i +: 2] == ST_M) begin
                any_m  = 1'b1;
                m_data = sdata_q[LINE_W*i +: LINE_W];
            end
        end
        src_data = any_m ? m_data : lo_data;
        if (op_q == 2'b11)                  op_eff = OP_RD;
        else if (op_q == OP_UPGR && any_m)  op_eff = OP_RDX;
        else                                op_eff = op_q;
    end

    // Next-state logic, resolve decisions and all output decoding
    always_comb begin
        state_nx      = state;
        res_data      = '0;
        res_rstate    = ST_I;
        res_ustate    = ST_I;
        resp_valid    = '0;
        resp_data     = '0;
        resp_state    = '0;
        snp_valid     = 1'b0;
        snp_mask      = '0;
        snp_op        = '0;
        snp_addr      = '0;
        snp_upd       = '0;
        snp_upd_state = '0;
        mem_valid     = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        busy          = (state != IDLE);
        case (state)
            IDLE: if (|req_valid) state_nx = SNOOP;
            SNOOP: begin
                snp_valid = 1'b1;
                snp_mask  = mask_q;
                snp_op    = op_q;
                snp_addr  = addr_q;
                if (all_acked) state_nx = RESOLVE;
            end
            RESOLVE: begin
                case (op_eff)
                    OP_RDX: begin
                        res_rstate = ST_M;
                        res_ustate = ST_I;
                        res_data   = src_data;
                        state_nx   = any_hit ? RESP : MEMRD;
                    end
                    OP_UPGR: begin
                        res_rstate = ST_M;
                        res_ustate = ST_I;
                        state_nx   = RESP;
                    end
                    default: begin
                        res_ustate = ST_S;
                        res_data   = src_data;
                        res_rstate = any_hit ? ST_S : ST_E;
                        if (any_m)        state_nx = WB;
                        else if (any_hit) state_nx = RESP;
                        else              state_nx = MEMRD;
                    end
                endcase
            end
            WB: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = data_q;
                if (mem_ack) state_nx = RESP;
            end
            MEMRD: begin
                mem_valid = 1'b1;
                mem_addr  = addr_q;
                if (mem_ack) state_nx = RESP;
            end
            RESP: begin
                resp_valid    = ~mask_q;
                resp_data     = data_q;
                resp_state    = rstate_q;
                snp_upd       = upd_q;
                snp_upd_state = ustate_q;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Grant latch, sticky snoop capture, resolve results and memory read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
            ack_q    <= '0;
            hit_q    <= '0;
            sstate_q <= '0;
            sdata_q  <= '0;
            data_q   <= '0;
            rstate_q <= '0;
            ustate_q <= '0;
            upd_q    <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    rr_ptr   <= (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx + IDX_W'(1);
                    op_q     <= gnt_op;
                    addr_q   <= gnt_addr;
                    mask_q   <= ~gnt_onehot;
                    ack_q    <= '0;
                    hit_q    <= '0;
                    sstate_q <= '0;
                    sdata_q  <= '0;
                end
                SNOOP: begin
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (mask_q[i] && snp_ack[i] && !ack_q[i]) begin
                            ack_q[i]                      <= 1'b1;
                            hit_q[i]                      <= snp_hit[i];
                            sstate_q[2*i +: 2]            <= snp_state[2*i +: 2];
                            sdata_q[LINE_W*i +: LINE_W]   <= snp_data[LINE_W*i +: LINE_W];
                        end
                    end
                end
                RESOLVE: begin
                    data_q   <= res_data;
                    rstate_q <= res_rstate;
                    ustate_q <= res_ustate;
                    upd_q    <= hit_q;
                end
                MEMRD: if (mem_ack) data_q <= mem_rdata;
                default: ;
            endcase
        end
    end
endmodule
